// File: rtl/avr_uart_rx.sv
// avr_uart_rx: 8N1 receiver for an AVR TXD line, with a small ready/valid receive FIFO.
// Optional macro AVR_UART_RX_PARITY_EN switches to 8E1 framing and adds the parity_err pulse.
module avr_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
`ifdef AVR_UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef AVR_UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t           state;
  logic             rx_in;
  logic [1:0]       sync;
  logic             line;
  logic             line_prev;
  logic [1:0]       fill;
  logic             armed;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
`ifdef AVR_UART_RX_PARITY_EN
  logic             par_bad;
`endif

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_next;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_next;

  logic expire_c, fall_c, full_c, pop_c, push_c, wr_c;

  // Anything that is not a clean 0 (1, x, z) counts as idle-high.
  always_comb begin
    rx_in = 1'b1;
    case (rxd)
      1'b0:    rx_in = 1'b0;
      default: rx_in = 1'b1;
    endcase
  end

  assign line     = sync[1];
  assign expire_c = (cnt == '0);
  assign fall_c   = armed && line_prev && !line;
  assign full_c   = (occ == OCC_FULL);
  assign pop_c    = valid && ready;

  always_comb begin
    push_c = (state == STOP) && expire_c && line;
`ifdef AVR_UART_RX_PARITY_EN
    if (par_bad) push_c = 1'b0;
`endif
    wr_c     = push_c && (!full_c || pop_c);
    rd_next  = rd_ptr + PTR_W'(1);
    occ_next = occ + OCC_W'(wr_c) - OCC_W'(pop_c);
  end

  // armed stays low until the line is seen high with real (post-reset) samples,
  // so a line held low across reset release cannot fake a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync      <= 2'b11;
      line_prev <= 1'b1;
      fill      <= 2'b00;
      armed     <= 1'b0;
    end else begin
      sync      <= {sync[0], rx_in};
      line_prev <= line;
      fill      <= {fill[0], 1'b1};
      armed     <= armed | (fill[1] & line);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      frame_err  <= 1'b0;
`ifdef AVR_UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
`ifdef AVR_UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (!expire_c) cnt <= cnt - CNT_W'(1);
      case (state)
        IDLE: if (fall_c) begin
          state <= START;
          cnt   <= HALF_BIT;
`ifdef AVR_UART_RX_PARITY_EN
          par_bad <= 1'b0;
`endif
        end
        START: if (expire_c) begin
          if (line) begin
            state <= IDLE;
          end else begin
            state   <= DATA;
            cnt     <= FULL_BIT;
            bit_idx <= '0;
          end
        end
        DATA: if (expire_c) begin
          shreg   <= {line, shreg[7:1]};
          cnt     <= FULL_BIT;
          bit_idx <= bit_idx + 3'd1;
`ifdef AVR_UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state <= PARITY;
`else
          if (bit_idx == 3'd7) state <= STOP;
`endif
        end
`ifdef AVR_UART_RX_PARITY_EN
        PARITY: if (expire_c) begin
          par_bad    <= (line != ^shreg);
          parity_err <= (line != ^shreg);
          cnt        <= FULL_BIT;
          state      <= STOP;
        end
`endif
        STOP: if (expire_c) begin
          if (line) begin
            state <= IDLE;
          end else begin
            frame_err <= 1'b1;
            state     <= BREAK;
          end
        end
        BREAK: if (line) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_c) mem[wr_ptr] <= shreg;
  end

  // data is a registered copy of the FIFO head, refreshed whenever the head changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      occ     <= '0;
      valid   <= 1'b0;
      data    <= 8'h00;
      overrun <= 1'b0;
    end else begin
      overrun <= push_c && full_c && !pop_c;
      if (wr_c)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c) rd_ptr <= rd_next;
      occ   <= occ_next;
      valid <= (occ_next != '0);
      if (pop_c) begin
        if (occ > OCC_W'(1)) data <= mem[rd_next];
        else if (wr_c)       data <= shreg;
      end else if ((occ == '0) && wr_c) begin
        data <= shreg;
      end
    end
  end

endmodule

// File: tb/tb_avr_uart_rx.sv
// tb_avr_uart_rx: table-driven frames plus hand sequences for FIFO, overrun, glitch, break and reset.
module tb_avr_uart_rx;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 4;
`ifdef AVR_UART_RX_PARITY_EN
  localparam bit USE_PAR = 1'b1;
`else
  localparam bit USE_PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
`ifdef AVR_UART_RX_PARITY_EN
  logic       parity_err;
`endif

  avr_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
`ifdef AVR_UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, pop_cnt = 0, valid_cyc = 0;
  logic [7:0] exp_q [$];

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         exp_fe;
    int         exp_valid;
  } vec_t;
  vec_t vec [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (USE_PAR) drive_bit(par_bit);
    drive_bit(stop_bit);
  endtask

  // Scoreboard side: count flag pulses and compare every popped byte to the queue head.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (valid)     valid_cyc++;
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
`ifdef AVR_UART_RX_PARITY_EN
      if (parity_err) pe_cnt++;
`endif
      if (valid && ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got data 0x%0h, want no pop", data);
        end else begin
          check("pop_data", 32'(data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int fe0, ov0, vc0, p0;
    vec[0] = '{8'h55, 1'b1, 0, 1};
    vec[1] = '{8'hA5, 1'b1, 0, 1};
    vec[2] = '{8'h00, 1'b1, 0, 1};
    vec[3] = '{8'hFF, 1'b1, 0, 1};
    vec[4] = '{8'h3C, 1'b0, 1, 0};
    vec[5] = '{8'h3C, 1'b1, 0, 1};
    vec[6] = '{8'h81, 1'b1, 0, 1};
    vec[7] = '{8'h7E, 1'b1, 0, 1};

    // Reset values
    repeat (3) @(negedge clk);
    #3;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'h00);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(10);

    // Single frames with ready=1; a bad stop bit is followed by a 40-cycle break
    for (int i = 0; i < 8; i++) begin
      fe0 = fe_cnt; ov0 = ov_cnt; vc0 = valid_cyc;
      ready = 1'b1;
      if (vec[i].exp_valid != 0) exp_q.push_back(vec[i].b);
      send_frame(vec[i].b, vec[i].stop, ^vec[i].b);
      if (!vec[i].stop) begin
        rxd = 1'b0;
        idle(40);
      end
      rxd = 1'b1;
      idle(20);
      check($sformatf("vec%0d_frame_err", i), 32'(fe_cnt - fe0), 32'(vec[i].exp_fe));
      check($sformatf("vec%0d_overrun", i), 32'(ov_cnt - ov0), 32'd0);
      check($sformatf("vec%0d_valid_cycles", i), 32'(valid_cyc - vc0), 32'(vec[i].exp_valid));
    end

    // Four bytes under back-pressure, then drained one per cycle
    ready = 1'b0;
    begin
      logic [7:0] burst [4];
      burst = '{8'hA5, 8'h01, 8'hFF, 8'h00};
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back(burst[i]);
        send_frame(burst[i], 1'b1, ^burst[i]);
      end
    end
    idle(5);
    #3;
    check("bp_valid", 32'(valid), 32'd1);
    check("bp_head", 32'(data), 32'hA5);
    idle(10);
    #3;
    check("bp_head_stable", 32'(data), 32'hA5);
    @(negedge clk);
    ready = 1'b1;
    p0 = pop_cnt;
    idle(4);
    #3;
    check("drain_valid_low", 32'(valid), 32'd0);
    check("drain_pops", 32'(pop_cnt - p0), 32'd4);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    ready = 1'b0;

    // Five bytes into a four-deep FIFO: last one dropped with one overrun pulse
    ov0 = ov_cnt;
    begin
      logic [7:0] five [5];
      five = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      for (int i = 0; i < 5; i++) begin
        if (i < 4) exp_q.push_back(five[i]);
        send_frame(five[i], 1'b1, ^five[i]);
      end
    end
    idle(5);
    #3;
    check("ovr_pulses", 32'(ov_cnt - ov0), 32'd1);
    check("ovr_head", 32'(data), 32'h11);
    @(negedge clk);
    ready = 1'b1;
    idle(8);
    check("ovr_queue_empty", 32'(exp_q.size()), 32'd0);
    check("ovr_valid_low", 32'(valid), 32'd0);

    // Eight-cycle low glitch is rejected
    fe0 = fe_cnt; ov0 = ov_cnt; vc0 = valid_cyc;
    rxd = 1'b0;
    idle(8);
    rxd = 1'b1;
    idle(200);
    check("glitch_valid", 32'(valid_cyc - vc0), 32'd0);
    check("glitch_frame_err", 32'(fe_cnt - fe0), 32'd0);
    check("glitch_overrun", 32'(ov_cnt - ov0), 32'd0);

    // Reset in the middle of a frame, with a byte waiting in the FIFO
    ready = 1'b0;
    send_frame(8'h5A, 1'b1, ^8'h5A);
    idle(3);
    #3;
    check("pre_rst_valid", 32'(valid), 32'd1);
    @(negedge clk);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(valid), 32'd0);
    check("async_rst_data", 32'(data), 32'h00);
    rxd = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(10);
    fe0 = fe_cnt; vc0 = valid_cyc;
    ready = 1'b1;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, ^8'hC3);
    rxd = 1'b1;
    idle(20);
    check("post_rst_frame_err", 32'(fe_cnt - fe0), 32'd0);
    check("post_rst_valid_cycles", 32'(valid_cyc - vc0), 32'd1);

    // Line already low at reset release must not start a frame
    rst = 1'b1;
    rxd = 1'b0;
    idle(3);
    rst = 1'b0;
    fe0 = fe_cnt; vc0 = valid_cyc;
    idle(30);
    rxd = 1'b1;
    idle(20);
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, ^8'h96);
    rxd = 1'b1;
    idle(20);
    check("low_rel_frame_err", 32'(fe_cnt - fe0), 32'd0);
    check("low_rel_valid_cycles", 32'(valid_cyc - vc0), 32'd1);

`ifdef AVR_UART_RX_PARITY_EN
    // Parity: 0x07 needs parity bit 1 for even parity
    p0 = pe_cnt; vc0 = valid_cyc;
    send_frame(8'h07, 1'b1, 1'b0);
    rxd = 1'b1;
    idle(20);
    check("par_bad_pulse", 32'(pe_cnt - p0), 32'd1);
    check("par_bad_no_push", 32'(valid_cyc - vc0), 32'd0);
    p0 = pe_cnt; vc0 = valid_cyc;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    rxd = 1'b1;
    idle(20);
    check("par_ok_pulse", 32'(pe_cnt - p0), 32'd0);
    check("par_ok_push", 32'(valid_cyc - vc0), 32'd1);
`endif

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/avr_uart_rx.md
AVR_UART_RX -- requirements
Module: avr_uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, giving clk cycles per serial bit; legal range is 4 or greater.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving receive FIFO entries; it SHALL be a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its posedge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port rxd, input, 1 bit: serial line, driven by the AVR TXD pin net.
REQ-006 SHALL have port data, output, 8 bits: FIFO head byte.
REQ-007 SHALL have port valid, output, 1 bit: FIFO non-empty.
REQ-008 SHALL have port ready, input, 1 bit: consumer accepts head byte.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port overrun, output, 1 bit: one-cycle pulse when a byte is dropped because the FIFO is full.
REQ-011 SHALL have port parity_err, output, 1 bit: one-cycle pulse on a parity mismatch; present only with AVR_UART_RX_PARITY_EN.

Function
REQ-012 SHALL resynchronise rxd through 2 flops; any rxd value other than 0 (1, x, z) SHALL be taken as 1.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP and BREAK.
REQ-014 IDLE: a 1->0 transition of the synchronised line SHALL enter START and load the bit counter with CLKS_PER_BIT/2-1.
REQ-015 START: at counter expiry, a sample of 0 SHALL enter DATA; a sample of 1 SHALL return to IDLE with no flag (glitch reject).
REQ-016 DATA: 8 bits SHALL be sampled, LSB first, each CLKS_PER_BIT cycles after the previous sample.
REQ-017 STOP: a sample of 1 SHALL push the byte and return to IDLE.
REQ-018 STOP: a sample of 0 SHALL discard the byte, pulse frame_err and enter BREAK.
REQ-019 BREAK SHALL wait for a synchronised 1 before entering IDLE.
REQ-020 A pushed byte SHALL appear on data with valid=1 on the cycle after the stop-bit sample when the FIFO was empty.
REQ-021 A pop SHALL occur on any posedge with valid=1 and ready=1; data SHALL advance to the next entry on the following cycle.
REQ-022 data SHALL remain stable while valid=1 and ready=0.
REQ-023 A push into a full FIFO with no pop SHALL drop the new byte, pulse overrun and leave FIFO contents unchanged.
REQ-024 A simultaneous push and pop on a full FIFO SHALL accept the push with no overrun.
REQ-025 A simultaneous push and pop on an empty FIFO SHALL be impossible, since valid=0.
REQ-026 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be held in a log2(FIFO_DEPTH)+1 bit counter.
REQ-027 The receiver SHALL run independently of ready; back-pressure SHALL never stall sampling.

Reset
REQ-028 On rst=1, immediately and independent of clk, the block SHALL go to IDLE, empty the FIFO and set the synchroniser flops to 1.
REQ-029 On rst=1, outputs SHALL be valid=0, data=8'h00, frame_err=0, overrun=0, parity_err=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame.
REQ-031 After reset release, a line already low SHALL NOT start a frame until a 1->0 transition is seen.

Configuration
REQ-032 With macro AVR_UART_RX_PARITY_EN defined, DATA SHALL be followed by PARITY, which samples one even-parity bit.
REQ-033 On a parity mismatch, the byte SHALL be discarded, parity_err pulsed, and STOP still checked.
REQ-034 Without the macro, there SHALL be no PARITY state and no parity_err port; frames SHALL be 8N1.

Verification
REQ-035 CLKS_PER_BIT=16, send 8N1 0x55, ready=1 -> valid=1 for exactly one cycle with data=0x55, 1 cycle after the stop sample; no flags.
REQ-036 Send 0xA5, 0x01, 0xFF, 0x00 with ready=0, then ready=1 -> bytes pop in that order, one per cycle; valid falls after the 4th.
REQ-037 FIFO_DEPTH=4, ready=0, send 5 bytes -> one overrun pulse at the 5th stop sample; the first 4 bytes are retained.
REQ-038 rxd low for 8 cycles, then high -> no state beyond START, no valid, no flags.
REQ-039 Frame 0x3C with stop bit 0, line held low 40 cycles -> frame_err pulse, no push, BREAK until high; a following 0x3C is received correctly.
REQ-040 Macro defined, send 0x07 with parity bit 0 -> parity_err pulse, no push; send 0x07 with parity bit 1 -> data=0x07.
